piece_drop_controller: RTL

Sequences the active piece's life cycle in the GAME clock domain: spawn, gravity fall, lock delay, lock, line clear. It owns the per-piece timers. It consumes the combinational landing flag from `piece_land_checker` (`active_piece_toutching`) and issues single-cycle move/lock commands to the game-state register. It sits between the input handler, the piece register and the fixed-board/line-clear logic.

---
 rtl/game_state_pkg.sv | 29 ++
 rtl/drop_timer.sv | 50 +++++
 rtl/piece_drop_controller.sv | 219 +++++++++++++++++++++
 3 files changed

// File: rtl/game_state_pkg.sv
// game_state_pkg
// Shared types and default timing constants for the game-state logic.
//   drop_ctrl_state_t      : life-cycle state of the active piece (3 bits)
//   *_DEFAULT              : default tick counts for gravity, soft drop,
//                            lock delay and lock-delay restarts
//   max_int()              : elaboration-time helper for sizing counters
package game_state_pkg;

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    SPAWN    = 3'd1,
    SETTLE   = 3'd2,
    FALL     = 3'd3,
    LOCK_DLY = 3'd4,
    LOCK     = 3'd5,
    CLEAR    = 3'd6,
    OVER     = 3'd7
  } drop_ctrl_state_t;

  localparam int GRAVITY_TICKS_DEFAULT   = 48;
  localparam int SOFT_TICKS_DEFAULT      = 4;
  localparam int LOCK_TICKS_DEFAULT      = 30;
  localparam int MAX_LOCK_RESETS_DEFAULT = 15;

  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/drop_timer.sv
// drop_timer
// Clearable, enable-gated up-counter with a terminal-count compare against a
// threshold supplied at run time.
//   clk, reset : GAME clock, asynchronous active-high reset
//   clear      : zero the count (wins over inc)
//   inc        : advance the count by one
//   threshold  : number of counted cycles per period (>= 1)
//   expired    : count has reached threshold-1
module drop_timer #(
  parameter int WIDTH = 6
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clear,
  input  logic             inc,
  input  logic [WIDTH-1:0] threshold,
  output logic             expired
);

  localparam logic [WIDTH-1:0] ONE  = WIDTH'(1);
  localparam logic [WIDTH-1:0] FULL = {WIDTH{1'b1}};

  logic [WIDTH-1:0] count_reg;
  logic [WIDTH-1:0] count_next;

  // Saturate instead of wrapping so a stalled period can never restart by
  // rolling over.
  always_comb begin
    count_next = count_reg;
    if (clear) begin
      count_next = '0;
    end else if (inc && (count_reg != FULL)) begin
      count_next = count_reg + ONE;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count_reg <= '0;
    end else begin
      count_reg <= count_next;
    end
  end

  // ">=" rather than "==": if the threshold drops below the current count
  // (soft drop pressed late in a gravity period) the period ends at once
  // instead of counting on forever.
  assign expired = (count_reg >= (threshold - ONE));

endmodule

// File: rtl/piece_drop_controller.sv
// piece_drop_controller
// Sequences the active piece: spawn, gravity fall, lock delay, lock, line
// clear. Owns the per-piece tick and lock-reset counters.
//   clk, reset              : GAME clock, asynchronous active-high reset
//   enable                  : game running; low pauses everything
//   no_piece                : piece register is empty
//   active_piece_toutching  : landing flag from piece_land_checker
//   soft_drop               : level, faster gravity
//   hard_drop               : pulse, drop until landed then lock at once
//   move_accepted           : pulse, a shift/rotate was applied
//   spawn_ack/spawn_blocked : new piece loaded / it overlaps the board
//   clear_done              : line clear finished
//   spawn_req, clear_req    : level requests (registered from state)
//   drop_req, lock_req      : single-cycle command pulses
//   game_over               : sticky
//   state                   : current FSM state for status/debug
module piece_drop_controller
  import game_state_pkg::*;
#(
  parameter int GRAVITY_TICKS   = GRAVITY_TICKS_DEFAULT,
  parameter int SOFT_TICKS      = SOFT_TICKS_DEFAULT,
  parameter int LOCK_TICKS      = LOCK_TICKS_DEFAULT,
  parameter int MAX_LOCK_RESETS = MAX_LOCK_RESETS_DEFAULT
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             enable,
  input  logic             no_piece,
  input  logic             active_piece_toutching,
  input  logic             soft_drop,
  input  logic             hard_drop,
  input  logic             move_accepted,
  input  logic             spawn_ack,
  input  logic             spawn_blocked,
  input  logic             clear_done,
  output logic             spawn_req,
  output logic             drop_req,
  output logic             lock_req,
  output logic             clear_req,
  output logic             game_over,
  output drop_ctrl_state_t state
);

  localparam int TICK_W = $clog2(max_int(GRAVITY_TICKS, LOCK_TICKS) + 1);
  localparam int RC_W   = (MAX_LOCK_RESETS < 1) ? 1 : $clog2(MAX_LOCK_RESETS + 1);

  localparam logic [TICK_W-1:0] GRAV_THR = TICK_W'(GRAVITY_TICKS);
  localparam logic [TICK_W-1:0] SOFT_THR = TICK_W'(SOFT_TICKS);
  localparam logic [TICK_W-1:0] LOCK_THR = TICK_W'(LOCK_TICKS);
  localparam logic [RC_W-1:0]   RC_MAX   = RC_W'(MAX_LOCK_RESETS);
  localparam logic [RC_W-1:0]   RC_ONE   = RC_W'(1);

  drop_ctrl_state_t state_reg, state_next;
  logic             hd_flag_reg, hd_flag_next;
  logic [RC_W-1:0]  reset_cnt_reg, reset_cnt_next;

  logic spawn_req_reg, drop_req_reg, lock_req_reg, clear_req_reg, game_over_reg;

  logic              timer_clear;
  logic              timer_inc;
  logic              timer_expired;
  logic [TICK_W-1:0] timer_threshold;
  logic              drop_fire;

  // One shared tick counter: the FSM is only ever timing gravity or the
  // lock delay, never both.
  drop_timer #(
    .WIDTH(TICK_W)
  ) u_drop_timer (
    .clk      (clk),
    .reset    (reset),
    .clear    (timer_clear),
    .inc      (timer_inc),
    .threshold(timer_threshold),
    .expired  (timer_expired)
  );

  // Threshold is resampled every cycle so soft_drop takes effect mid-count.
  always_comb begin
    timer_threshold = GRAV_THR;
    if (state_reg == LOCK_DLY) begin
      timer_threshold = LOCK_THR;
    end else if (soft_drop) begin
      timer_threshold = SOFT_THR;
    end
  end

  always_comb begin
    state_next     = state_reg;
    hd_flag_next   = hd_flag_reg;
    reset_cnt_next = reset_cnt_reg;
    timer_clear    = 1'b0;
    timer_inc      = 1'b0;
    drop_fire      = 1'b0;

    // Everything, including acks, is ignored while paused.
    if (enable) begin
      case (state_reg)
        IDLE: begin
          state_next = SPAWN;
        end

        SPAWN: begin
          if (spawn_ack) begin
            state_next = spawn_blocked ? OVER : SETTLE;
          end
        end

        // The landing checker still sees the previous position here.
        SETTLE: begin
          timer_clear = 1'b1;
          state_next  = FALL;
        end

        FALL: begin
          if (active_piece_toutching) begin
            if (hd_flag_reg) begin
              state_next = LOCK;
            end else begin
              timer_clear = 1'b1;
              state_next  = LOCK_DLY;
            end
          end else if (hd_flag_reg || hard_drop) begin
            drop_fire    = 1'b1;
            hd_flag_next = 1'b1;
            state_next   = SETTLE;
          end else if (timer_expired) begin
            drop_fire  = 1'b1;
            state_next = SETTLE;
          end else begin
            timer_inc = 1'b1;
          end
        end

        LOCK_DLY: begin
          if (hard_drop) begin
            state_next = LOCK;
          end else if (move_accepted && (reset_cnt_reg < RC_MAX)) begin
            reset_cnt_next = reset_cnt_reg + RC_ONE;
            state_next     = SETTLE;
          end else if (!active_piece_toutching) begin
            state_next = SETTLE;
          end else if (timer_expired) begin
            state_next = LOCK;
          end else begin
            timer_inc = 1'b1;
          end
        end

        LOCK: begin
          state_next = CLEAR;
        end

        CLEAR: begin
          if (clear_done) begin
            state_next = SPAWN;
          end
        end

        OVER: begin
          state_next = OVER;
        end

        default: begin
          state_next = IDLE;
        end
      endcase

      // Piece vanished underneath us: respawn without locking anything.
      if (no_piece && ((state_reg == SETTLE) || (state_reg == FALL) ||
                       (state_reg == LOCK_DLY))) begin
        state_next = SPAWN;
        drop_fire  = 1'b0;
      end

      // Fresh piece starts with clean timers and flags.
      if (state_next == SPAWN) begin
        timer_clear    = 1'b1;
        timer_inc      = 1'b0;
        reset_cnt_next = '0;
        hd_flag_next   = 1'b0;
      end
    end
  end

  // Outputs are registered decodes of the state, one cycle behind it.
  // Level outputs freeze during pause; pulse outputs are gated by enable.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_reg     <= IDLE;
      hd_flag_reg   <= 1'b0;
      reset_cnt_reg <= '0;
      spawn_req_reg <= 1'b0;
      drop_req_reg  <= 1'b0;
      lock_req_reg  <= 1'b0;
      clear_req_reg <= 1'b0;
      game_over_reg <= 1'b0;
    end else begin
      state_reg     <= state_next;
      hd_flag_reg   <= hd_flag_next;
      reset_cnt_reg <= reset_cnt_next;
      drop_req_reg  <= drop_fire;
      lock_req_reg  <= enable && (state_reg == LOCK);
      if (enable) begin
        spawn_req_reg <= (state_reg == SPAWN);
        clear_req_reg <= (state_reg == CLEAR);
      end
      game_over_reg <= game_over_reg || (state_reg == OVER);
    end
  end

  assign spawn_req = spawn_req_reg;
  assign drop_req  = drop_req_reg;
  assign lock_req  = lock_req_reg;
  assign clear_req = clear_req_reg;
  assign game_over = game_over_reg;
  assign state     = state_reg;

endmodule
